// File: rtl/matrix_pkg.sv
// Shared definitions for the LED matrix column scanner and the row/pattern
// logic that follows it.
//   scan_state_t : scanner FSM states
//   half_cols()  : number of slots in a mirrored frame, ceil(cols/2)
package matrix_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_BLANK = 2'd2
  } scan_state_t;

  function automatic int half_cols(input int cols);
    return (cols + 1) / 2;
  endfunction

endpackage

// File: rtl/matrix_column_scanner_if.sv
// Column scanner bus: controls in, registered column drive and status out.
//   enable, mirror          : from controller (master) to scanner (slave)
//   col, col_index          : active column mask and slot number
//   frame_start, blanking   : slot-0 pulse and blank-gap flag
interface matrix_column_scanner_if #(
  parameter int COLS = 5
);
  localparam int IW = $clog2(COLS);

  logic            enable;
  logic            mirror;
  logic [COLS-1:0] col;
  logic [IW-1:0]   col_index;
  logic            frame_start;
  logic            blanking;

  modport master (
    output enable, mirror,
    input  col, col_index, frame_start, blanking
  );

  modport slave (
    input  enable, mirror,
    output col, col_index, frame_start, blanking
  );
endinterface

// File: rtl/matrix_column_scanner_column_mask_decoder.sv
// Combinational slot-to-column decoder.
//   slot   : slot number; slot s drives column COLS-1-s
//   mirror : when high, slot s also drives column s
//   mask   : COLS-bit active-high column mask
module column_mask_decoder #(
  parameter int COLS = 5
) (
  input  logic [$clog2(COLS)-1:0] slot,
  input  logic                    mirror,
  output logic [COLS-1:0]         mask
);

  always_comb begin
    mask = '0;
    for (int i = 0; i < COLS; i++) begin
      if (i == COLS - 1 - int'(slot)) mask[i] = 1'b1;
      if (mirror && (i == int'(slot))) mask[i] = 1'b1;
    end
  end

endmodule

// File: rtl/matrix_column_scanner.sv
// Parametrised LED matrix column scanner with mirror mode, per-slot dwell
// and an optional blanking gap between slots.
//   clock : system clock, rising edge
//   reset : asynchronous, active-low
//   bus   : scanner bus (slave side) - enable/mirror in, col/col_index/
//           frame_start/blanking out, all outputs registered
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_IDLE  | scan stopped, columns off
// ST_DRIVE | current slot's mask driven for DWELL cycles
// ST_BLANK | all columns off for BLANK cycles after a slot
module matrix_column_scanner
  import matrix_pkg::*;
#(
  parameter int COLS  = 5,
  parameter int DWELL = 1,
  parameter int BLANK = 0
) (
  input  logic              clock,
  input  logic              reset,
  matrix_column_scanner_if.slave bus
);

  localparam int SW      = $clog2(COLS);
  localparam int CNT_RAW = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CW      = $clog2((CNT_RAW > 2) ? CNT_RAW : 2);

  localparam logic [CW-1:0] DWELL_TC  = CW'(DWELL - 1);
  localparam logic [CW-1:0] BLANK_TC  = CW'((BLANK > 0) ? BLANK - 1 : 0);
  localparam logic [SW-1:0] LAST_FULL = SW'(COLS - 1);
  localparam logic [SW-1:0] LAST_HALF = SW'(half_cols(COLS) - 1);

  scan_state_t      state_q, state_d;
  logic [SW-1:0]    slot_q, slot_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             mir_q, mir_d;
  logic             drive_d, fs_d, blank_d, advance;
  logic [SW-1:0]    last_slot;
  logic [COLS-1:0]  mask_d;

  // Mask is decoded from the next slot/mirror so col lines up with col_index.
  column_mask_decoder #(.COLS(COLS)) u_mask_dec (
    .slot   (slot_d),
    .mirror (mir_d),
    .mask   (mask_d)
  );

  assign last_slot = mir_q ? LAST_HALF : LAST_FULL;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      slot_q  <= '0;
      cnt_q   <= '0;
      mir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      cnt_q   <= cnt_d;
      mir_q   <= mir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    cnt_d   = cnt_q;
    mir_d   = mir_q;
    drive_d = 1'b0;
    fs_d    = 1'b0;
    blank_d = 1'b0;
    advance = 1'b0;

    if (!bus.enable) begin
      state_d = ST_IDLE;
      slot_d  = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_DRIVE;
          slot_d  = '0;
          cnt_d   = '0;
          mir_d   = bus.mirror;
          drive_d = 1'b1;
          fs_d    = 1'b1;
        end
        ST_DRIVE: begin
          if (cnt_q == DWELL_TC) begin
            if (BLANK > 0) begin
              state_d = ST_BLANK;
              cnt_d   = '0;
              blank_d = 1'b1;
            end else begin
              advance = 1'b1;
            end
          end else begin
            cnt_d   = cnt_q + 1'b1;
            drive_d = 1'b1;
          end
        end
        ST_BLANK: begin
          if (cnt_q == BLANK_TC) begin
            advance = 1'b1;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            blank_d = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          slot_d  = '0;
          cnt_d   = '0;
        end
      endcase

      // End of a slot's last cycle: step to the next slot, or wrap and
      // re-latch mirror so a mid-frame change only takes effect here.
      if (advance) begin
        state_d = ST_DRIVE;
        cnt_d   = '0;
        drive_d = 1'b1;
        if (slot_q == last_slot) begin
          slot_d = '0;
          mir_d  = bus.mirror;
          fs_d   = 1'b1;
        end else begin
          slot_d = slot_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bus.col         <= '0;
      bus.col_index   <= '0;
      bus.frame_start <= 1'b0;
      bus.blanking    <= 1'b0;
    end else begin
      bus.col         <= drive_d ? mask_d : '0;
      bus.col_index   <= slot_d;
      bus.frame_start <= fs_d;
      bus.blanking    <= blank_d;
    end
  end

endmodule

// File: doc/matrix_column_scanner.md
# matrix_column_scanner

Parametrised column driver for the LED matrix. It generalises the fixed 5-column ring counter to any column count, with a runtime mirror mode, a per-column dwell time and a blanking gap between columns. It sits between the system clock and the matrix column lines. Row data logic uses `col_index` and `frame_start` to select the pattern slice for the active column.

## Interface
- `COLS`, default 5: number of matrix columns; at least 2.
- `DWELL`, default 1: clock cycles each slot is driven; at least 1.
- `BLANK`, default 0: cycles with all columns off after each slot, for anti-ghosting; 0 or more.
- `clock`  in  1: single system clock; all state updates on its rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `enable`  in  1: scan runs while high.
- `mirror`  in  1: mirrored-image mode; sampled only at frame boundaries.
- `col`  out  COLS: column drive, active-high, registered.
- `col_index`  out  $clog2(COLS): current slot number, registered.
- `frame_start`  out  1: one-cycle pulse in the first drive cycle of slot 0.
- `blanking`  out  1: high during blank cycles.

## Operation
- **Slot count.** SLOTS = COLS when the latched mirror flag is 0, and ceil(COLS/2) when it is 1.
- **Slot-to-column mapping.**
  - Slot s drives column COLS-1-s, so the scan starts at the MSB and moves toward bit 0.
  - In mirror mode, slot s also drives column s. Both bits are high, and the image is symmetric.
  - When COLS is odd, the middle slot drives one bit only.
- **States.**
  - IDLE: `col`=0, `col_index`=0.
  - DRIVE: `col`=mask(slot); dwell counter counts DWELL cycles.
  - BLANK: `col`=0, `blanking`=1; counter counts BLANK cycles.
- **Transitions.**
  - IDLE→DRIVE(slot 0) on a clock edge with `enable`=1. On that edge the latched mirror flag is loaded from `mirror`.
  - DRIVE→BLANK when the counter reaches DWELL-1 and BLANK>0.
  - When BLANK=0, the DRIVE state advances straight to the next slot's DRIVE.
  - BLANK→DRIVE(next slot) when the counter reaches BLANK-1.
- **Slot advance and wrap.** The slot advances at the end of each slot's last cycle. After slot SLOTS-1 it wraps to 0. At the wrap, the mirror flag is re-latched from `mirror`, and `frame_start` pulses in the first cycle of the new slot 0.
- **Enable low.** Any state goes to IDLE on the next edge. Outputs clear, the slot and counter clear, and the next enable starts a fresh frame with `frame_start`.
- **Mirror change mid-frame.** Ignored until the wrap; the current frame completes in its original mode.
- **Frame period.** SLOTS×(DWELL+BLANK) cycles.
- **Counter width.** The dwell/blank counter is $clog2(max(DWELL,BLANK,2)) bits. It never exceeds its terminal value.

## Timing
- **Reset values.** `col`=0, `col_index`=0, `frame_start`=0, `blanking`=0. State is IDLE and the mirror flag is 0.
- **Reset assertion.** Takes effect immediately, without waiting for a clock. Outputs are forced to the reset values even mid-slot.
- **Start latency.** The first rising edge with `reset` deasserted and `enable`=1 produces `col`=mask(0) and `frame_start`=1: one cycle from enable.
- **Output stability.** All outputs come from registers and change only on a clock edge.
- **At most one active slot.** `col` never shows two slots' masks in the same cycle. In BLANK=0 operation, column changes are a single-edge switch.

## Structure
- **Shared package `matrix_pkg`.** Holds the scanner state enum (IDLE, DRIVE, BLANK) and the slot-count function ceil(COLS/2), for reuse by the row/pattern logic.
- **Sub-module `column_mask_decoder`.** Combinational; maps (slot, mirror) to a COLS-bit mask. It is instantiated once, and its output is registered into `col`.

## Test plan
- **Normal scan.** COLS=5, DWELL=1, BLANK=0, mirror=0, enable=1 → `col` = 10000, 01000, 00100, 00010, 00001, then repeats. `frame_start` is high every 5th cycle, starting in the first cycle.
- **Mirror scan.** Same parameters with mirror=1 → `col` = 10001, 01010, 00100, repeating with period 3; `col_index` = 0, 1, 2.
- **Dwell and blank.** DWELL=3, BLANK=1, mirror=0 → each mask held for 3 cycles, then one cycle of `col`=0 with `blanking`=1. Frame period is 20 and `frame_start` repeats every 20 cycles.
- **Mirror toggle mid-frame.** Raise `mirror` during slot 2 → slots 3 and 4 remain single-bit. The next frame runs 10001, 01010, 00100.
- **Enable drop.** Drop `enable` during slot 3 → `col`=0 on the next edge. Re-enable → `col`=10000 with `frame_start`=1 one cycle later.
- **Reset mid-slot.** Assert `reset` low between clock edges → all outputs are 0 immediately. After release with `enable` high, the scan restarts at slot 0.
